// File: rtl/sigma_delta_pkg.sv
// Shared types and helpers for the sigma-delta feeder (sample widths up to MAX_W bits).
package sigma_delta_pkg;

   localparam int MAX_W = 32;

   typedef enum logic [1:0] {
      OFF       = 2'd0,
      RAMP_UP   = 2'd1,
      RUN       = 2'd2,
      RAMP_DOWN = 2'd3
   } feeder_state_t;

   function automatic logic [MAX_W-1:0] mid_value(input int w);
      return MAX_W'(1) << (w - 1);
   endfunction

   // Signed two's complement to offset binary is an MSB flip; the caller truncates to w bits.
   function automatic logic [MAX_W-1:0] to_offset_binary(input logic signed [MAX_W-1:0] s,
                                                         input int w);
      return s ^ mid_value(w);
   endfunction

endpackage

// File: rtl/sigma_delta_feeder_if.sv
// Sample stream from the mixer into the sigma-delta feeder (valid/ready).
interface sigma_delta_feeder_if #(
   parameter int N = 16
);
   logic signed [N-1:0] s_data;
   logic                s_valid;
   logic                s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO with a synchronous flush; DEPTH must be a power of 2.
module sample_fifo #(
   parameter int N     = 16,
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                n_reset,
   input  logic                flush,
   input  logic                push,
   input  logic signed [N-1:0] din,
   input  logic                pop,
   output logic signed [N-1:0] dout,
   output logic                full,
   output logic                empty
);
   localparam int AW = $clog2(DEPTH);

   logic signed [N-1:0] mem [DEPTH];
   logic [AW-1:0]       rd_ptr;
   logic [AW-1:0]       wr_ptr;
   logic [AW:0]         count;
   logic                do_push;
   logic                do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/sigma_delta_feeder.sv
// Paces buffered audio samples onto the sigma-delta DAC word with pop-free soft start/stop.
// Optional SIGMA_DELTA_FEEDER_UNDERRUN_CNT_EN adds a saturating underrun counter output.
module sigma_delta_feeder
   import sigma_delta_pkg::*;
#(
   parameter int         N         = 16,
   parameter int         DIV       = 20,
   parameter int         DEPTH     = 4,
   parameter logic [N-1:0] RAMP_STEP = N'(16'h0100)
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              enable,
   input  logic              clr_underrun,
   sigma_delta_feeder_if.slave s,
   output logic [N-1:0]      dac_in,
   output logic              sample_tick,
   output logic              running,
   output logic              underrun
`ifdef SIGMA_DELTA_FEEDER_UNDERRUN_CNT_EN
   ,output logic [7:0]       underrun_cnt
`endif
);
   localparam int           CW          = $clog2(DIV);
   localparam logic [N-1:0] MID         = N'(mid_value(N));
   localparam logic [1:0]   S_OFF       = 2'(OFF);
   localparam logic [1:0]   S_RAMP_UP   = 2'(RAMP_UP);
   localparam logic [1:0]   S_RUN       = 2'(RUN);
   localparam logic [1:0]   S_RAMP_DOWN = 2'(RAMP_DOWN);

   // Re-entry into RAMP_UP can start above MID, so the step is taken toward MID from either side.
   function automatic logic [N-1:0] step_to_mid(input logic [N-1:0] v);
      logic [N:0] up;
      up = {1'b0, v} + {1'b0, RAMP_STEP};
      if (v < MID) return (up >= {1'b0, MID}) ? MID : up[N-1:0];
      else         return ((v - MID) > RAMP_STEP) ? (v - RAMP_STEP) : MID;
   endfunction

   function automatic logic [N-1:0] sat_sub_step(input logic [N-1:0] v);
      return (v > RAMP_STEP) ? (v - RAMP_STEP) : '0;
   endfunction

   logic [CW-1:0]       div_cnt;
   logic [1:0]          state;
   logic [1:0]          state_nxt;
   logic [N-1:0]        dac_nxt;
   logic [N-1:0]        ramp_up_val;
   logic [N-1:0]        ramp_dn_val;
   logic signed [N-1:0] fifo_head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_flush;
   logic                underrun_evt;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         div_cnt     <= CW'(DIV - 1);
         sample_tick <= 1'b0;
      end else if (div_cnt == '0) begin
         div_cnt     <= CW'(DIV - 1);
         sample_tick <= 1'b1;
      end else begin
         div_cnt     <= div_cnt - 1'b1;
         sample_tick <= 1'b0;
      end
   end

   assign s.s_ready    = (state != S_OFF) && !fifo_full;
   assign fifo_push    = s.s_valid && s.s_ready;
   assign ramp_up_val  = step_to_mid(dac_in);
   assign ramp_dn_val  = sat_sub_step(dac_in);
   assign fifo_pop     = sample_tick && (state == S_RUN) && enable && !fifo_empty;
   assign underrun_evt = sample_tick && (state == S_RUN) && enable && fifo_empty;
   assign fifo_flush   = (state == S_OFF) ||
                         (sample_tick && (state == S_RAMP_DOWN) && (state_nxt == S_OFF));

   sample_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .n_reset (n_reset),
      .flush   (fifo_flush),
      .push    (fifo_push),
      .din     (s.s_data),
      .pop     (fifo_pop),
      .dout    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_nxt = state;
      dac_nxt   = dac_in;
      case (state)
         S_OFF: begin
            dac_nxt = '0;
            if (enable) state_nxt = S_RAMP_UP;
         end
         S_RAMP_UP: begin
            if (!enable) begin
               state_nxt = S_RAMP_DOWN;
            end else begin
               dac_nxt = ramp_up_val;
               if (ramp_up_val == MID) state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (!enable)          state_nxt = S_RAMP_DOWN;
            else if (!fifo_empty) dac_nxt   = N'(to_offset_binary(MAX_W'(fifo_head), N));
         end
         default: begin
            if (enable) begin
               state_nxt = S_RAMP_UP;
            end else begin
               dac_nxt = ramp_dn_val;
               if (ramp_dn_val == '0) state_nxt = S_OFF;
            end
         end
      endcase
   end

   // State and DAC word only move on sample ticks.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state   <= S_OFF;
         dac_in  <= '0;
         running <= 1'b0;
      end else if (sample_tick) begin
         state   <= state_nxt;
         dac_in  <= dac_nxt;
         running <= (state_nxt == S_RUN);
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)          underrun <= 1'b0;
      else if (underrun_evt) underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;
   end

`ifdef SIGMA_DELTA_FEEDER_UNDERRUN_CNT_EN
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         underrun_cnt <= 8'd0;
      end else if (underrun_evt) begin
         if (clr_underrun)               underrun_cnt <= 8'd1;
         else if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
      end else if (clr_underrun) begin
         underrun_cnt <= 8'd0;
      end
   end
`endif

endmodule

// File: tb/tb_sigma_delta_feeder.sv
// Scoreboard bench for sigma_delta_feeder: a behavioural model predicts every cycle and tick.
module tb_sigma_delta_feeder;
   localparam int          N     = 16;
   localparam int          DIV   = 4;
   localparam int          DEPTH = 4;
   localparam logic [15:0] STEP  = 16'h2000;
   localparam int          MID   = 32768;
   localparam int          M_OFF = 0, M_UP = 1, M_RUN = 2, M_DOWN = 3;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        enable = 1'b0;
   logic        clr = 1'b0;
   logic [15:0] dac_in;
   logic        sample_tick;
   logic        running;
   logic        underrun;
`ifdef SIGMA_DELTA_FEEDER_UNDERRUN_CNT_EN
   logic [7:0]  underrun_cnt;
`endif

   sigma_delta_feeder_if #(.N(N)) sif ();

   sigma_delta_feeder #(.N(N), .DIV(DIV), .DEPTH(DEPTH), .RAMP_STEP(STEP)) dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .enable       (enable),
      .clr_underrun (clr),
      .s            (sif),
      .dac_in       (dac_in),
      .sample_tick  (sample_tick),
      .running      (running),
      .underrun     (underrun)
`ifdef SIGMA_DELTA_FEEDER_UNDERRUN_CNT_EN
      ,.underrun_cnt (underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [15:0] dac;
      logic        run;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: mode, DAC value and FIFO contents as plain integers and a queue.
   int m_mode, m_dac, m_cnt, k;
   bit m_und;
   int m_q[$];

   always @(negedge clk) begin : model
      bit tk, ready, uflag;
      int head;
      if (!n_reset) begin
         m_mode = M_OFF; m_dac = 0; m_und = 0; m_cnt = 0; k = 0;
         m_q.delete();
      end else begin
         tk    = (k > 0) && (k % DIV == 0);
         ready = (m_mode != M_OFF) && (m_q.size() < DEPTH);
         check("sample_tick", int'(sample_tick), int'(tk));
         check("s_ready", int'(sif.s_ready), int'(ready));
         check("underrun", int'(underrun), int'(m_und));
`ifdef SIGMA_DELTA_FEEDER_UNDERRUN_CNT_EN
         check("underrun_cnt", int'(underrun_cnt), m_cnt);
`endif
         uflag = 0;
         if (tk) begin
            case (m_mode)
               M_OFF: begin
                  m_dac = 0;
                  if (enable) m_mode = M_UP;
               end
               M_UP: begin
                  if (!enable) m_mode = M_DOWN;
                  else begin
                     if (m_dac < MID) m_dac = (m_dac + STEP > MID) ? MID : m_dac + STEP;
                     else             m_dac = (m_dac - STEP < MID) ? MID : m_dac - STEP;
                     if (m_dac == MID) m_mode = M_RUN;
                  end
               end
               M_RUN: begin
                  if (!enable) m_mode = M_DOWN;
                  else if (m_q.size() > 0) begin
                     head  = m_q.pop_front();
                     m_dac = head + 32768;
                  end else uflag = 1;
               end
               default: begin
                  if (enable) m_mode = M_UP;
                  else begin
                     m_dac = (m_dac > STEP) ? m_dac - STEP : 0;
                     if (m_dac == 0) m_mode = M_OFF;
                  end
               end
            endcase
            exp_q.push_back('{dac: 16'(m_dac), run: (m_mode == M_RUN)});
         end
         if (uflag) begin
            m_und = 1;
            m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
         end else if (clr) begin
            m_und = 0;
            m_cnt = 0;
         end
         if (sif.s_valid && ready) m_q.push_back(int'(sif.s_data));
         if (m_mode == M_OFF) m_q.delete();
         k++;
      end
   end

   // Monitor: the edge after each sample tick presents a new DAC word.
   bit prev_tick;
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!n_reset) begin
         prev_tick = 0;
         exp_q.delete();
      end else begin
         if (prev_tick) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL scoreboard: tick output 0x%0h with no expected entry", dac_in);
            end else begin
               e = exp_q.pop_front();
               check("dac_in", int'(dac_in), int'(e.dac));
               check("running", int'(running), int'(e.run));
            end
         end
         prev_tick = sample_tick;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick();
      int i = 0;
      while (!sample_tick && i < 4*DIV) begin
         step();
         i++;
      end
      if (!sample_tick) begin
         tests++; fails++;
         $display("FAIL tick_timeout: got no sample_tick, required one within %0d clks", 4*DIV);
      end
   endtask

   task automatic tick_step(input int n);
      for (int i = 0; i < n; i++) begin
         wait_tick();
         step();
      end
   endtask

   task automatic push(input logic [15:0] d);
      bit done = 0;
      sif.s_data  = d;
      sif.s_valid = 1'b1;
      for (int i = 0; i < 64 && !done; i++) begin
         done = sif.s_ready;
         step();
      end
      sif.s_valid = 1'b0;
      if (!done) begin
         tests++; fails++;
         $display("FAIL push_timeout: sample 0x%0h got no s_ready, required acceptance", d);
      end
   endtask

   initial begin
      int guard;
      sif.s_valid = 1'b0;
      sif.s_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dac_in", int'(dac_in), 0);
      check("rst_sample_tick", int'(sample_tick), 0);
      check("rst_running", int'(running), 0);
      check("rst_underrun", int'(underrun), 0);
      check("rst_s_ready", int'(sif.s_ready), 0);
      n_reset = 1'b1;
      repeat (20) step();
      check("idle_dac_in", int'(dac_in), 0);

      // Soft start while the FIFO fills; the fifth sample stalls until RUN pops.
      enable = 1'b1;
      tick_step(1);
      push(16'h0000);
      push(16'h7FFF);
      push(16'h8000);
      push(16'hFFFF);
      check("full_s_ready", int'(sif.s_ready), 0);
      push(16'h1234);
      tick_step(8);
      check("underrun_set", int'(underrun), 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("underrun_clr", int'(underrun), 0);
      tick_step(3);
`ifdef SIGMA_DELTA_FEEDER_UNDERRUN_CNT_EN
      check("underrun_cnt3", int'(underrun_cnt), 3);
`endif

      // Soft stop from full scale with two samples left to be flushed.
      push(16'h7FFF);
      tick_step(1);
      check("run_full_scale", int'(dac_in), 16'hFFFF);
      enable = 1'b0;
      push(16'h1111);
      push(16'h2222);
      tick_step(10);
      check("off_dac_in", int'(dac_in), 0);
      check("off_running", int'(running), 0);

      // Reverse the ramp mid-way in both directions.
      enable = 1'b1;
      guard = 0;
      while (dac_in != 16'h4000 && guard < 10) begin
         tick_step(1);
         guard++;
      end
      check("ramp_at_4000", int'(dac_in), 16'h4000);
      enable = 1'b0;
      tick_step(1);
      check("reverse_hold", int'(dac_in), 16'h4000);
      tick_step(1);
      check("reverse_down", int'(dac_in), 16'h2000);
      enable = 1'b1;
      tick_step(1);
      check("reverse_up_hold", int'(dac_in), 16'h2000);
      tick_step(3);
      check("reramp_mid", int'(dac_in), 16'h8000);
      check("reramp_running", int'(running), 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      tick_step(1);
      check("flushed_underrun", int'(underrun), 1);
      check("flushed_hold", int'(dac_in), 16'h8000);

      // Randomised traffic, enable toggling and clears.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) enable = ~enable;
         sif.s_valid = 1'($urandom_range(0, 1));
         sif.s_data  = 16'($urandom);
         clr         = ($urandom_range(0, 29) == 0);
         step();
      end
      sif.s_valid = 1'b0;
      clr         = 1'b0;

      // Asynchronous reset in the middle of RUN.
      enable = 1'b1;
      tick_step(10);
      check("pre_reset_running", int'(running), 1);
      push(16'h4000);
      #2;
      n_reset = 1'b0;
      #1;
      check("arst_dac_in", int'(dac_in), 0);
      check("arst_sample_tick", int'(sample_tick), 0);
      check("arst_running", int'(running), 0);
      check("arst_underrun", int'(underrun), 0);
      check("arst_s_ready", int'(sif.s_ready), 0);
      enable = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_reset = 1'b1;
      repeat (12) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sigma_delta_feeder.md
Name: sigma_delta_feeder

Overview:
- Sample-rate controller that sequences the N-bit sigma-delta DAC input word.
- Buffers signed audio samples from the mixer through a valid/ready handshake in a small FIFO, and paces them out at a fixed sample tick derived from clk.
- Runs a soft-start/soft-stop state machine that ramps the DAC word between 0 and midscale, so enable/disable causes no audible pop.
- Detects FIFO underrun and flags it; on underrun the last value is held.

Parameters:
- N, 16, sample and DAC word width.
- DIV, 20, clk cycles per sample tick (>= 2).
- DEPTH, 4, FIFO depth in samples (power of 2, >= 2).
- RAMP_STEP, 16'h0100, DAC-word change per tick while ramping (N bits, nonzero).

Ports:
- clk  input  1  clock.
- n_reset  input  1  asynchronous, active-low reset.
- enable  input  1  request audio output; sampled only on sample_tick.
- s_data  input  N  signed two's-complement sample.
- s_valid  input  1  s_data valid.
- s_ready  output  1  FIFO can accept a sample.
- dac_in  output  N  unsigned offset-binary word to the DAC input.
- sample_tick  output  1  one-clk pulse per sample period.
- running  output  1  high in RUN state.
- underrun  output  1  sticky underrun flag.
- clr_underrun  input  1  clears underrun (and counter if present).

Behaviour:
- Reset (async, n_reset=0): dac_in=0, sample_tick=0, running=0, underrun=0, s_ready=0, state=OFF, divider=DIV-1, FIFO empty.
- Divider: free-running down-counter DIV-1..0, independent of state.
  - sample_tick is registered and high for the one clk when the counter wraps 0 -> DIV-1.
  - First tick occurs DIV clks after reset release.
- Handshake:
  - s_ready = (state != OFF) && !fifo_full.
  - A transfer occurs when s_valid && s_ready at a clk edge.
  - Push and pop in the same cycle are both performed, so the count is unchanged even when full.
- Offset conversion: dac word = s_data with its MSB inverted. MID = 1 << (N-1).
- FSM: states OFF, RAMP_UP, RUN, RAMP_DOWN. All state and dac_in changes happen only on edges where sample_tick=1.
  - OFF:
    - dac_in=0; FIFO held flushed.
    - enable=1 -> RAMP_UP.
  - RAMP_UP:
    - dac_in moves toward MID by RAMP_STEP, clamped at MID. This works from either side, since re-entry can start above MID.
    - If the new value == MID -> RUN, same edge.
    - enable=0 -> RAMP_DOWN, with no step taken on this tick.
  - RUN:
    - enable=0 -> RAMP_DOWN; no pop and dac_in holds.
    - Else if FIFO not empty: pop; dac_in = converted head sample.
    - Else: dac_in holds and underrun is set.
  - RAMP_DOWN:
    - dac_in = max(dac_in - RAMP_STEP, 0), unsigned saturating.
    - If the result is 0 -> OFF, and the FIFO is flushed on the same edge.
    - enable=1 -> RAMP_UP, with no step taken on this tick.
- Latency: a sample pushed at least one clk before a RUN tick appears on dac_in on that tick edge. Samples pop in FIFO order.
- underrun: set on an underrun tick and cleared by clr_underrun. If both occur in the same cycle, set wins.
- running is registered and equals (state == RUN).

Optional Feature:
- Macro: SIGMA_DELTA_FEEDER_UNDERRUN_CNT_EN.
- Defined:
  - Adds output underrun_cnt [7:0], reset 0.
  - Increments on every underrun tick and saturates at 8'hFF.
  - clr_underrun zeroes it; if a clear and an increment coincide, the result is 1.
- Undefined: the port and counter are absent; only the sticky flag exists.

Decomposition:
- Package sigma_delta_pkg holds:
  - typedef enum feeder_state_t {OFF, RAMP_UP, RUN, RAMP_DOWN};
  - the function to_offset_binary(N-bit signed);
  - a MID constant helper.
- One sub-module, sample_fifo: synchronous FIFO with parameters N and DEPTH, push/pop, full/empty, and a synchronous flush input.

Test Plan (N=16, DIV=4, DEPTH=4, RAMP_STEP=16'h2000):
- Reset, enable=0 for 20 clks -> dac_in=0, s_ready=0, sample_tick every 4 clks, first tick 4 clks after release.
- Enable=1 -> dac_in on successive ticks is 0x2000, 0x4000, 0x6000, 0x8000; running=1 from the 0x8000 tick.
- In RUN, push 0x0000, 0x7FFF, 0x8000, 0xFFFF, then push a 5th sample with the FIFO full -> s_ready=0 and the 5th sample is stalled. dac_in on ticks is 0x8000, 0xFFFF, 0x0000, 0x7FFF.
- RUN with an empty FIFO at a tick -> dac_in holds, underrun=1. clr_underrun pulse -> 0. With the macro defined, 3 underrun ticks -> underrun_cnt=3.
- RUN at dac_in=0xFFFF, enable=0 -> RAMP_DOWN ticks give 0xDFFF, 0xBFFF, …, 0x1FFF, 0x0000, then OFF. FIFO holding 2 samples is flushed at OFF.
- Enable=0 at 0x4000 during RAMP_UP, then enable=1 one tick later -> 0x4000 held, then 0x2000, then 0x2000 held, then ramps up to 0x8000.
- Assert n_reset mid-RUN -> all outputs return to reset values immediately, asynchronously.
